// File: rtl/tpu_pkg.sv
// Opcode encodings and sequencer state type shared by the TPU control path.
package tpu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP          = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_LOAD_ADDR    = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_LOAD_WEIGHT  = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_LOAD_INPUTS  = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_VALID        = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_STORE        = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_RSVD         = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_HALT         = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_WAIT_UNIT,
        S_HALTED
    } seq_state_t;

endpackage

// File: rtl/tpu_sequencer.sv
// Fetches one ISA word at a time, issues it to the decoder for exactly one cycle and
// stalls on unit ops until unit_done; 3 cycles start->first issue, 3 cycles per non-waiting op.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int IMEM_DEPTH   = 64,
    parameter int PC_W         = $clog2(IMEM_DEPTH),
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               unit_done,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int WDOG_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        (WAIT_TIMEOUT == 0) ? '0 : WDOG_W'(WAIT_TIMEOUT - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

    seq_state_t          state, state_nxt;
    logic [PC_W-1:0]     pc_nxt;
    logic [INSTR_W-1:0]  ir, ir_nxt;
    logic [WDOG_W-1:0]   wdog, wdog_nxt;
    logic                done_nxt, error_nxt;
    logic                advance;
    logic [OPCODE_W-1:0] opcode;

    assign opcode = ir[INSTR_W-1 -: OPCODE_W];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        wdog_nxt  = wdog;
        done_nxt  = done;
        error_nxt = error;
        advance   = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                end
            end
            S_FETCH:    state_nxt = S_WAIT_MEM;
            S_WAIT_MEM: begin
                ir_nxt    = imem_rdata;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                case (opcode)
                    OP_NOP, OP_LOAD_ADDR: advance = 1'b1;
                    OP_LOAD_WEIGHT, OP_LOAD_INPUTS, OP_VALID, OP_STORE: begin
                        state_nxt = S_WAIT_UNIT;
                        wdog_nxt  = '0;
                    end
                    OP_HALT: begin
                        state_nxt = S_HALTED;
                        done_nxt  = 1'b1;
                    end
                    default: begin
                        state_nxt = S_HALTED;
                        done_nxt  = 1'b1;
                        error_nxt = 1'b1;
                    end
                endcase
            end
            S_WAIT_UNIT: begin
                wdog_nxt = wdog + WDOG_W'(1);
                // A completion arriving on the expiry cycle still counts as success.
                if (unit_done) begin
                    advance = 1'b1;
                end else if (WAIT_TIMEOUT != 0 && wdog == WDOG_LAST) begin
                    state_nxt = S_HALTED;
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Running off the end of imem is a program error, never a wrap to 0.
        if (advance) begin
            if (pc == PC_LAST) begin
                state_nxt = S_HALTED;
                done_nxt  = 1'b1;
                error_nxt = 1'b1;
            end else begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            wdog  <= '0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            wdog  <= wdog_nxt;
            done  <= done_nxt;
            error <= error_nxt;
        end
    end

    assign imem_rd_en  = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign instr_out   = (state == S_ISSUE) ? ir : '0;
    assign busy        = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboarded bench for tpu_sequencer: expected issue words (and optional issue cycles)
// are queued when a program is loaded and checked as the sequencer issues them.
module tb_tpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ud_manual = 1'b0;
    logic        ud_auto = 1'b0;
    logic        unit_done;
    logic        imem_rd_en, instr_valid, busy, done, error;
    logic [5:0]  imem_addr, pc;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr_out;

    logic        start_b = 1'b0;
    logic        zero_b = 1'b0;
    logic        rd_en_b, valid_b, busy_b, done_b, error_b;
    logic [1:0]  addr_b, pc_b;
    logic [15:0] rdata_b = '0;
    logic [15:0] instr_b;

    logic [15:0] mem [64];
    logic [15:0] mem_b [4];

    typedef struct {
        logic [15:0] instr;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_issue = 0;
    int   b_issues = 0;
    int   ud_delay = 0;
    int   ud_cnt = 0;

    assign unit_done = ud_auto | ud_manual;

    tpu_sequencer #(.INSTR_W(16), .IMEM_DEPTH(64), .WAIT_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid), .unit_done(unit_done),
        .pc(pc), .busy(busy), .done(done), .error(error)
    );

    tpu_sequencer #(.INSTR_W(16), .IMEM_DEPTH(4), .WAIT_TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .imem_rd_en(rd_en_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .instr_out(instr_b), .instr_valid(valid_b), .unit_done(zero_b),
        .pc(pc_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        if (rd_en_b) rdata_b <= mem_b[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue monitor / scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (instr_valid) begin
                last_issue = cyc;
                if (exp_q.size() == 0) begin
                    chk("issue_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", instr_out, e.instr);
                    if (e.cyc >= 0) chk("issue_cyc", cyc, e.cyc);
                end
            end else if (busy) begin
                chk("nop_out", instr_out, 0);
            end
            if (valid_b && instr_b == 16'h0000) b_issues++;
        end
    end

    // Unit model: pulses unit_done ud_delay cycles after a waiting op issues.
    always @(negedge clk) begin
        ud_auto = 1'b0;
        if (reset) begin
            ud_cnt = 0;
        end else begin
            if (ud_cnt > 0) begin
                ud_cnt--;
                if (ud_cnt == 0) ud_auto = 1'b1;
            end
            if (instr_valid && ud_delay > 0 && instr_out[15:13] inside {3'd2, 3'd3, 3'd4, 3'd5})
                ud_cnt = ud_delay;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'hE000;
    endtask

    task automatic put(input int idx, input logic [15:0] w, input int ecyc);
        mem[idx] = w;
        exp_q.push_back('{instr: w, cyc: ecyc});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
        dc = cyc;
    endtask

    initial begin
        int s, dc, n;
        for (int i = 0; i < 4; i++) mem_b[i] = 16'h0000;
        clear_mem();
        tick(2);
        chk("rst_outs", {busy, done, error, instr_valid, imem_rd_en, pc, instr_out}, 0);
        reset = 1'b0;
        tick();

        // 1: mixed program with unit completions two cycles after issue
        ud_delay = 2;
        s = cyc;
        put(0, 16'h2010, s + 3);
        put(1, 16'h4001, -1);
        put(2, 16'h6002, -1);
        put(3, 16'h8003, -1);
        put(4, 16'hA004, -1);
        put(5, 16'hE000, -1);
        pulse_start();
        wait_done("t1_done", dc);
        chk("t1_error", error, 0);
        chk("t1_pc", pc, 5);
        chk("t1_sb_empty", exp_q.size(), 0);

        // 2: non-waiting ops, one issue every 3 cycles
        ud_delay = 0;
        clear_mem();
        s = cyc;
        put(0, 16'h0000, s + 3);
        put(1, 16'h3FFF, s + 6);
        put(2, 16'hE000, s + 9);
        pulse_start();
        wait_done("t2_done", dc);
        chk("t2_done_cyc", dc - s, 10);
        chk("t2_error", error, 0);
        chk("t2_pc", pc, 2);

        // 3: watchdog expiry, then restart clears error
        clear_mem();
        put(0, 16'h4000, -1);
        pulse_start();
        wait_done("t3_done", dc);
        chk("t3_wait_cycles", dc - last_issue, 9);
        chk("t3_error", error, 1);
        chk("t3_pc", pc, 0);
        ud_delay = 2;
        put(0, 16'h4000, -1);
        put(1, 16'hE000, -1);
        pulse_start();
        chk("t3_restart", {busy, imem_rd_en, done, error, pc}, {2'b11, 2'b00, 6'd0});
        wait_done("t3_rerun_done", dc);
        chk("t3_rerun_error", error, 0);
        chk("t3_rerun_pc", pc, 1);

        // 4: reserved opcode, then PC overrun on a 4-deep imem
        ud_delay = 0;
        clear_mem();
        put(0, 16'hC000, -1);
        pulse_start();
        wait_done("t4_done", dc);
        chk("t4_error", error, 1);
        chk("t4_pc", pc, 0);
        chk("t4_sb_empty", exp_q.size(), 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 100) begin
            tick();
            n++;
        end
        chk("t4b_done", done_b, 1);
        chk("t4b_error", error_b, 1);
        chk("t4b_pc", pc_b, 3);
        chk("t4b_issues", b_issues, 4);
        chk("t4b_busy", busy_b, 0);

        // 5: async reset mid WAIT_UNIT, unit_done in IDLE, start while busy
        clear_mem();
        put(0, 16'h4000, -1);
        pulse_start();
        tick(4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("t5_async_rst", {busy, done, error, instr_valid, imem_rd_en, pc, instr_out}, 0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        ud_manual = 1'b1;
        tick();
        ud_manual = 1'b0;
        tick();
        chk("t5_idle_ud", {busy, done, error, pc}, 0);
        clear_mem();
        put(0, 16'h4000, -1);
        put(1, 16'h0000, -1);
        put(2, 16'hE000, -1);
        pulse_start();
        tick(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_busy", {busy, imem_rd_en, instr_valid, pc}, {3'b100, 6'd0});
        ud_manual = 1'b1;
        tick();
        ud_manual = 1'b0;
        wait_done("t5_done", dc);
        chk("t5_pc", pc, 2);
        chk("t5_error", error, 0);

        // 6a: unit_done during ISSUE is not a completion
        clear_mem();
        put(0, 16'h4000, -1);
        put(1, 16'hE000, -1);
        pulse_start();
        tick(2);
        chk("t6_issue_seen", instr_valid, 1);
        ud_manual = 1'b1;
        tick();
        ud_manual = 1'b0;
        tick(2);
        chk("t6_still_wait", {busy, instr_valid, imem_rd_en, done}, 4'b1000);
        ud_manual = 1'b1;
        tick();
        ud_manual = 1'b0;
        wait_done("t6a_done", dc);
        chk("t6a_error", error, 0);
        chk("t6a_pc", pc, 1);

        // 6b: unit_done on the watchdog expiry cycle wins
        ud_delay = 8;
        put(0, 16'h4000, -1);
        put(1, 16'hE000, -1);
        pulse_start();
        wait_done("t6b_done", dc);
        chk("t6b_error", error, 0);
        chk("t6b_pc", pc, 1);

        chk("sb_final_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
